lsb_rs_param: RTL and testbench
===============================

Name: lsb_rs_param

Overview:
- Parametrised in-order reservation station between dispatch and the load/store buffer (LSB).
- Holds up to DEPTH memory ops in program order and snoops N_CDB broadcast buses to wake up operands.
- Issues the head entry to the LSB over a valid/ready handshake once both operands are ready.
- Successor to the fixed-size LSB RS. Adds: dispatch-cycle CDB bypass, all DEPTH slots usable, count/almost-full outputs, registered issue stage with backpressure, and a generic CDB count.

Parameters:
DEPTH, 16, entry count; power of two, >=2
DATA_W, 32, operand/immediate width
TAG_W, 4, ROB tag width
OP_W, 6, opcode width
N_CDB, 4, number of CDB channels; lower index wins on tag collision
AFULL_SLACK, 2, almost_full asserts when count >= DEPTH-AFULL_SLACK

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
rdy  in  1  global enable; 0 freezes all state
clear  in  1  synchronous flush (mispredict)
full  out  1  count==DEPTH
almost_full  out  1  see AFULL_SLACK
count  out  log2(DEPTH)+1  occupied entries
disp_valid  in  1  dispatch push
disp_op  in  OP_W  opcode
disp_imm  in  DATA_W  offset
disp_r1_valid / disp_r2_valid  in  1 each  operand value ready
disp_r1_data / disp_r2_data  in  DATA_W each  operand value
disp_r1_tag / disp_r2_tag  in  TAG_W each  producer tag when not ready
disp_dest_tag  in  TAG_W  ROB tag of this op
cdb_valid  in  N_CDB  per-channel valid
cdb_tag  in  N_CDB*TAG_W  channel k at [k*TAG_W +: TAG_W]
cdb_data  in  N_CDB*DATA_W  channel k at [k*DATA_W +: DATA_W]
iss_valid  out  1  issue register holds an op
iss_ready  in  1  LSB accepts
iss_op / iss_imm  out  OP_W / DATA_W  issued opcode / offset
iss_base / iss_data  out  DATA_W each  operand1 (base), operand2 (store data)
iss_dest_tag  out  TAG_W  ROB tag

Behaviour:
- Reset (rst=0, async): head=tail=0, count=0; all entry valid bits 0; iss_valid=0; iss_* = 0; full=0, almost_full=0.
- Priority at each clock edge: rst > clear > !rdy (hold everything) > normal operation.
- clear: empties the queue and zeroes iss_valid/iss_*. Dispatch, issue and wakeup in that cycle are discarded.
- Push:
  - Occurs when disp_valid && !full, with full taken from the registered count. A push into a full RS is dropped and state is unchanged; dispatch must not do this, and the bench flags it.
  - The entry is written at tail; tail wraps DEPTH-1 -> 0.
- Dispatch bypass: if disp_rX_valid=0 and a CDB channel matches disp_rX_tag in the same cycle, the entry is stored ready with that CDB's data.
- Wakeup:
  - Every cycle, each valid entry with a non-ready operand compares its tag against all valid CDB channels.
  - On a match it latches the data and sets ready at the edge; the lowest channel index wins.
  - A ready operand is never overwritten.
- Issue stage:
  - Load condition: head entry valid, both operands ready (registered state), and (!iss_valid || iss_ready).
  - On load: iss_* are loaded, iss_valid=1, the head entry is invalidated, and head advances with wrap.
  - If (iss_valid && iss_ready) with no head load, iss_valid drops to 0.
  - iss_* stay stable while iss_valid && !iss_ready.
- Ordering: strictly in order. A non-ready head blocks younger ready entries.
- Latency:
  - Dispatch with both operands ready at edge N -> iss_valid=1 after edge N+1.
  - CDB wakeup of the last operand at edge N -> issue at N+1.
  - Back-to-back ready ops issue one per cycle while iss_ready=1.
- count: +1 on push, -1 on pop, unchanged on simultaneous push+pop.
- full/almost_full: combinational from count.
- Full boundary: a push and a pop in the same edge while count==DEPTH is impossible because full blocks the push. When count==DEPTH-1, a push and a pop on the same edge leave count at DEPTH-1.

Test Plan:
1. Reset mid-operation: 3 entries queued, iss_valid=1, pulse rst=0 asynchronously -> count=0, iss_valid=0 immediately, no clock required.
2. Ready dispatch: push op=LW, base=0x1000, imm=4, tag=3 at edge 0 -> edge 1: iss_valid=1, iss_base=0x1000, iss_imm=4, iss_dest_tag=3.
3. Wakeup and order: push A (r1 tag 5, pending), then B (ready). CDB1 broadcasts tag5=0x2000 at edge 4 -> A issues at edge 5, B at edge 6. B never issues before A.
4. Bypass and collision: push with r1 tag 7 pending while CDB0 and CDB2 both carry tag 7 (0xAA / 0xBB) -> entry stored ready with 0xAA and issues the next cycle.
5. Full, wrap and backpressure: DEPTH=4, iss_ready=0, push 5 ops -> count=4, full=1, almost_full=1 from count 2, 5th push dropped. Raise iss_ready -> 4 issues in order, iss_* stable while stalled, then the next 4 pushes wrap tail correctly.
6. Flush: 3 entries queued, iss_valid=1, clear=1 together with disp_valid=1 -> next edge count=0, iss_valid=0, the pushed op is discarded. rdy=0 for 3 cycles with CDB activity -> no state change.

Source files
------------

// File: rtl/lsb_rs_param_if.sv
// rtl/lsb_rs_param_if.sv - dispatch, CDB snoop and issue signal bundle for the LSB reservation station
interface lsb_rs_param_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int N_CDB  = 4
);
    logic                    disp_valid;
    logic [OP_W-1:0]         disp_op;
    logic [DATA_W-1:0]       disp_imm;
    logic                    disp_r1_valid;
    logic [DATA_W-1:0]       disp_r1_data;
    logic [TAG_W-1:0]        disp_r1_tag;
    logic                    disp_r2_valid;
    logic [DATA_W-1:0]       disp_r2_data;
    logic [TAG_W-1:0]        disp_r2_tag;
    logic [TAG_W-1:0]        disp_dest_tag;

    logic [N_CDB-1:0]        cdb_valid;
    logic [N_CDB*TAG_W-1:0]  cdb_tag;
    logic [N_CDB*DATA_W-1:0] cdb_data;

    logic                    iss_valid;
    logic                    iss_ready;
    logic [OP_W-1:0]         iss_op;
    logic [DATA_W-1:0]       iss_imm;
    logic [DATA_W-1:0]       iss_base;
    logic [DATA_W-1:0]       iss_data;
    logic [TAG_W-1:0]        iss_dest_tag;

    modport master (
        output disp_valid, disp_op, disp_imm,
        output disp_r1_valid, disp_r1_data, disp_r1_tag,
        output disp_r2_valid, disp_r2_data, disp_r2_tag, disp_dest_tag,
        output cdb_valid, cdb_tag, cdb_data,
        output iss_ready,
        input  iss_valid, iss_op, iss_imm, iss_base, iss_data, iss_dest_tag
    );

    modport slave (
        input  disp_valid, disp_op, disp_imm,
        input  disp_r1_valid, disp_r1_data, disp_r1_tag,
        input  disp_r2_valid, disp_r2_data, disp_r2_tag, disp_dest_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        input  iss_ready,
        output iss_valid, iss_op, iss_imm, iss_base, iss_data, iss_dest_tag
    );
endinterface

// File: rtl/lsb_rs_param.sv
// rtl/lsb_rs_param.sv - in-order memory-op reservation station with CDB wakeup and registered issue stage
module lsb_rs_param #(
    parameter int DEPTH       = 16,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 4,
    parameter int OP_W        = 6,
    parameter int N_CDB       = 4,
    parameter int AFULL_SLACK = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   clear,
    output logic                   full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    lsb_rs_param_if.slave          bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0]  valid_q, r1_rdy_q, r2_rdy_q;
    logic [OP_W-1:0]   op_q      [DEPTH];
    logic [DATA_W-1:0] imm_q     [DEPTH];
    logic [DATA_W-1:0] r1_data_q [DEPTH];
    logic [DATA_W-1:0] r2_data_q [DEPTH];
    logic [TAG_W-1:0]  r1_tag_q  [DEPTH];
    logic [TAG_W-1:0]  r2_tag_q  [DEPTH];
    logic [TAG_W-1:0]  dest_q    [DEPTH];

    logic [AW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q;

    logic              iss_valid_q;
    logic [OP_W-1:0]   iss_op_q;
    logic [DATA_W-1:0] iss_imm_q, iss_base_q, iss_data_q;
    logic [TAG_W-1:0]  iss_dest_q;

    // {hit, data} for one tag; scanning high-to-low lets the lowest channel win.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]        tag,
        input logic [N_CDB-1:0]        v,
        input logic [N_CDB*TAG_W-1:0]  tags,
        input logic [N_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int k = N_CDB - 1; k >= 0; k--) begin
            if (v[k] && (tags[k*TAG_W +: TAG_W] == tag))
                r = {1'b1, data[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    logic [DATA_W:0] wk1 [DEPTH];
    logic [DATA_W:0] wk2 [DEPTH];
    logic [DATA_W:0] disp_r1_hit, disp_r2_hit;
    logic            push, pop;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk1[i] = cdb_lookup(r1_tag_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            wk2[i] = cdb_lookup(r2_tag_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
    end

    assign disp_r1_hit = cdb_lookup(bus.disp_r1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    assign disp_r2_hit = cdb_lookup(bus.disp_r2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = (int'(count_q) >= (DEPTH - AFULL_SLACK));
    assign count       = count_q;

    // Head readiness uses registered state only, so a wakeup costs one cycle before issue.
    assign push = bus.disp_valid && !full;
    assign pop  = valid_q[head_q] && r1_rdy_q[head_q] && r2_rdy_q[head_q]
                  && (!iss_valid_q || bus.iss_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            r1_rdy_q    <= '0;
            r2_rdy_q    <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_imm_q   <= '0;
            iss_base_q  <= '0;
            iss_data_q  <= '0;
            iss_dest_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]      <= '0;
                imm_q[i]     <= '0;
                r1_data_q[i] <= '0;
                r2_data_q[i] <= '0;
                r1_tag_q[i]  <= '0;
                r2_tag_q[i]  <= '0;
                dest_q[i]    <= '0;
            end
        end else if (clear) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_imm_q   <= '0;
            iss_base_q  <= '0;
            iss_data_q  <= '0;
            iss_dest_q  <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && !r1_rdy_q[i] && wk1[i][DATA_W]) begin
                    r1_rdy_q[i]  <= 1'b1;
                    r1_data_q[i] <= wk1[i][DATA_W-1:0];
                end
                if (valid_q[i] && !r2_rdy_q[i] && wk2[i][DATA_W]) begin
                    r2_rdy_q[i]  <= 1'b1;
                    r2_data_q[i] <= wk2[i][DATA_W-1:0];
                end
            end

            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + AW'(1);
                iss_valid_q     <= 1'b1;
                iss_op_q        <= op_q[head_q];
                iss_imm_q       <= imm_q[head_q];
                iss_base_q      <= r1_data_q[head_q];
                iss_data_q      <= r2_data_q[head_q];
                iss_dest_q      <= dest_q[head_q];
            end else if (iss_valid_q && bus.iss_ready) begin
                iss_valid_q <= 1'b0;
            end

            // The tail slot is never the popped head: pop needs a valid head, push a free tail.
            if (push) begin
                valid_q[tail_q]   <= 1'b1;
                op_q[tail_q]      <= bus.disp_op;
                imm_q[tail_q]     <= bus.disp_imm;
                dest_q[tail_q]    <= bus.disp_dest_tag;
                r1_tag_q[tail_q]  <= bus.disp_r1_tag;
                r2_tag_q[tail_q]  <= bus.disp_r2_tag;
                r1_rdy_q[tail_q]  <= bus.disp_r1_valid || disp_r1_hit[DATA_W];
                r2_rdy_q[tail_q]  <= bus.disp_r2_valid || disp_r2_hit[DATA_W];
                r1_data_q[tail_q] <= bus.disp_r1_valid ? bus.disp_r1_data : disp_r1_hit[DATA_W-1:0];
                r2_data_q[tail_q] <= bus.disp_r2_valid ? bus.disp_r2_data : disp_r2_hit[DATA_W-1:0];
                tail_q            <= tail_q + AW'(1);
            end

            if (push && !pop)
                count_q <= count_q + CW'(1);
            else if (!push && pop)
                count_q <= count_q - CW'(1);
        end
    end

    assign bus.iss_valid    = iss_valid_q;
    assign bus.iss_op       = iss_op_q;
    assign bus.iss_imm      = iss_imm_q;
    assign bus.iss_base     = iss_base_q;
    assign bus.iss_data     = iss_data_q;
    assign bus.iss_dest_tag = iss_dest_q;
endmodule

// File: tb/tb_lsb_rs_param.sv
// tb/tb_lsb_rs_param.sv - directed self-checking bench for lsb_rs_param at DEPTH=4
module tb_lsb_rs_param;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 6;
    localparam int N_CDB  = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       rdy   = 1'b1;
    logic       clear = 1'b0;
    logic       full, almost_full;
    logic [2:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    lsb_rs_param_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W), .N_CDB(N_CDB)) bus ();

    lsb_rs_param #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W),
        .N_CDB(N_CDB), .AFULL_SLACK(2)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .full(full), .almost_full(almost_full), .count(count),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [5:0] op, input logic [31:0] imm,
                            input logic r1v, input logic [31:0] r1d, input logic [3:0] r1t,
                            input logic r2v, input logic [31:0] r2d, input logic [3:0] r2t,
                            input logic [3:0] dest);
        bus.disp_valid    = 1'b1;
        bus.disp_op       = op;
        bus.disp_imm      = imm;
        bus.disp_r1_valid = r1v;
        bus.disp_r1_data  = r1d;
        bus.disp_r1_tag   = r1t;
        bus.disp_r2_valid = r2v;
        bus.disp_r2_data  = r2d;
        bus.disp_r2_tag   = r2t;
        bus.disp_dest_tag = dest;
    endtask

    task automatic push_rdy(input logic [3:0] dest, input logic [31:0] base);
        set_disp(6'h03, 32'h0, 1'b1, base, 4'h0, 1'b1, 32'h0, 4'h0, dest);
    endtask

    task automatic no_disp();
        bus.disp_valid = 1'b0;
    endtask

    task automatic cdb_set(input int ch, input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_valid[ch]               = 1'b1;
        bus.cdb_tag[ch*TAG_W +: TAG_W]  = tag;
        bus.cdb_data[ch*DATA_W +: DATA_W] = data;
    endtask

    task automatic cdb_off();
        bus.cdb_valid = '0;
    endtask

    initial begin
        bus.disp_valid = 1'b0;
        bus.disp_op = '0; bus.disp_imm = '0;
        bus.disp_r1_valid = 1'b0; bus.disp_r1_data = '0; bus.disp_r1_tag = '0;
        bus.disp_r2_valid = 1'b0; bus.disp_r2_data = '0; bus.disp_r2_tag = '0;
        bus.disp_dest_tag = '0;
        bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.iss_ready = 1'b0;

        #12;
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_iss_valid", bus.iss_valid, 0);
        check("rst_iss_base", bus.iss_base, 0);
        rst = 1'b1;
        step();

        // Fill to 3 queued + 1 in issue, then push+pop at count==DEPTH-1, then async reset
        for (int i = 0; i < 4; i++) begin
            push_rdy(4'(i), 32'h10 + 32'(i));
            step();
        end
        no_disp();
        check("t1_count", count, 3);
        check("t1_iss_valid", bus.iss_valid, 1);
        check("t1_iss_dest", bus.iss_dest_tag, 0);
        check("t1_afull", almost_full, 1);
        check("t1_full", full, 0);
        bus.iss_ready = 1'b1;
        push_rdy(4'd4, 32'h14);
        step();
        no_disp();
        bus.iss_ready = 1'b0;
        check("t1_pushpop_count", count, 3);
        check("t1_pushpop_dest", bus.iss_dest_tag, 1);
        #1 rst = 1'b0;
        #1;
        check("t1_async_count", count, 0);
        check("t1_async_iss_valid", bus.iss_valid, 0);
        check("t1_async_iss_dest", bus.iss_dest_tag, 0);
        check("t1_async_afull", almost_full, 0);
        rst = 1'b1;

        // Ready dispatch: one cycle to issue
        bus.iss_ready = 1'b1;
        set_disp(6'h03, 32'd4, 1'b1, 32'h1000, 4'h0, 1'b1, 32'h0, 4'h0, 4'd3);
        step();
        no_disp();
        check("t2_count", count, 1);
        check("t2_iss_valid0", bus.iss_valid, 0);
        step();
        check("t2_iss_valid", bus.iss_valid, 1);
        check("t2_iss_op", bus.iss_op, 6'h03);
        check("t2_iss_base", bus.iss_base, 32'h1000);
        check("t2_iss_imm", bus.iss_imm, 4);
        check("t2_iss_dest", bus.iss_dest_tag, 3);
        check("t2_count_after", count, 0);
        step();
        check("t2_iss_drop", bus.iss_valid, 0);

        // Wakeup and in-order issue
        set_disp(6'h23, 32'd8, 1'b0, 32'h0, 4'd5, 1'b1, 32'h11, 4'h0, 4'd1);
        step();
        set_disp(6'h23, 32'd12, 1'b1, 32'h3000, 4'h0, 1'b1, 32'h22, 4'h0, 4'd2);
        step();
        no_disp();
        check("t3_count", count, 2);
        check("t3_blocked0", bus.iss_valid, 0);
        step();
        check("t3_blocked1", bus.iss_valid, 0);
        cdb_set(1, 4'd5, 32'h2000);
        cdb_set(0, 4'd9, 32'hDEAD);
        step();
        cdb_off();
        check("t3_wake_edge", bus.iss_valid, 0);
        step();
        check("t3_a_valid", bus.iss_valid, 1);
        check("t3_a_dest", bus.iss_dest_tag, 1);
        check("t3_a_base", bus.iss_base, 32'h2000);
        check("t3_a_data", bus.iss_data, 32'h11);
        step();
        check("t3_b_dest", bus.iss_dest_tag, 2);
        check("t3_b_base", bus.iss_base, 32'h3000);
        check("t3_b_data", bus.iss_data, 32'h22);
        step();
        check("t3_done_valid", bus.iss_valid, 0);
        check("t3_done_count", count, 0);

        // Dispatch bypass with CDB collision: channel 0 beats channel 2
        set_disp(6'h03, 32'h0, 1'b0, 32'h0, 4'd7, 1'b1, 32'h22, 4'h0, 4'd4);
        cdb_set(0, 4'd7, 32'hAA);
        cdb_set(2, 4'd7, 32'hBB);
        step();
        no_disp();
        cdb_off();
        check("t4_count", count, 1);
        step();
        check("t4_valid", bus.iss_valid, 1);
        check("t4_base", bus.iss_base, 32'hAA);
        check("t4_dest", bus.iss_dest_tag, 4);
        step();
        check("t4_drop", bus.iss_valid, 0);

        // Full, drop, backpressure and tail wrap
        bus.iss_ready = 1'b0;
        set_disp(6'h03, 32'h0, 1'b0, 32'h0, 4'd9, 1'b1, 32'h0, 4'h0, 4'd8);
        step();
        check("t5_count1", count, 1);
        check("t5_afull1", almost_full, 0);
        for (int i = 1; i <= 4; i++) begin
            int exp_cnt;
            push_rdy(4'(8 + i), 32'h100 + 32'(i));
            step();
            exp_cnt = (i < 4) ? i + 1 : 4;
            check("t5_fill_count", count, 64'(exp_cnt));
            check("t5_fill_full", full, 64'(exp_cnt == 4));
            check("t5_fill_afull", almost_full, 64'(exp_cnt >= 2));
        end
        no_disp();
        check("t5_no_issue", bus.iss_valid, 0);
        cdb_set(3, 4'd9, 32'h900);
        step();
        cdb_off();
        check("t5_wake_edge", bus.iss_valid, 0);
        step();
        check("t5_head_valid", bus.iss_valid, 1);
        check("t5_head_dest", bus.iss_dest_tag, 8);
        check("t5_head_base", bus.iss_base, 32'h900);
        check("t5_head_count", count, 3);
        step();
        check("t5_stall_valid", bus.iss_valid, 1);
        check("t5_stall_dest", bus.iss_dest_tag, 8);
        check("t5_stall_base", bus.iss_base, 32'h900);
        bus.iss_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t5_drain_dest", bus.iss_dest_tag, 64'(8 + i));
            check("t5_drain_base", bus.iss_base, 64'(32'h100 + 32'(i)));
        end
        step();
        check("t5_drained_valid", bus.iss_valid, 0);
        check("t5_drained_count", count, 0);
        for (int i = 0; i < 4; i++) begin
            push_rdy(4'(12 + i), 32'h200 + 32'(i));
            step();
            check("t5_wrap_count", count, 1);
            if (i > 0) check("t5_wrap_dest", bus.iss_dest_tag, 64'(12 + i - 1));
        end
        no_disp();
        step();
        check("t5_wrap_last_dest", bus.iss_dest_tag, 15);
        check("t5_wrap_last_base", bus.iss_base, 32'h203);
        check("t5_wrap_last_count", count, 0);
        step();
        check("t5_wrap_idle", bus.iss_valid, 0);

        // Flush with simultaneous dispatch, then rdy freeze
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_rdy(4'(i), 32'h40 + 32'(i));
            step();
        end
        check("t6_pre_count", count, 3);
        check("t6_pre_valid", bus.iss_valid, 1);
        clear = 1'b1;
        push_rdy(4'd7, 32'h77);
        cdb_set(0, 4'd1, 32'h5);
        step();
        clear = 1'b0;
        no_disp();
        cdb_off();
        check("t6_clr_count", count, 0);
        check("t6_clr_valid", bus.iss_valid, 0);
        check("t6_clr_base", bus.iss_base, 0);
        check("t6_clr_dest", bus.iss_dest_tag, 0);
        bus.iss_ready = 1'b1;
        step();
        check("t6_discard_count", count, 0);
        check("t6_discard_valid", bus.iss_valid, 0);
        set_disp(6'h03, 32'h0, 1'b0, 32'h0, 4'd6, 1'b1, 32'h0, 4'h0, 4'd5);
        step();
        no_disp();
        check("t6_pend_count", count, 1);
        rdy = 1'b0;
        push_rdy(4'd9, 32'h99);
        cdb_set(0, 4'd6, 32'h600);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_frz_count", count, 1);
            check("t6_frz_valid", bus.iss_valid, 0);
        end
        rdy = 1'b1;
        no_disp();
        cdb_off();
        step();
        check("t6_thaw_valid", bus.iss_valid, 0);
        check("t6_thaw_count", count, 1);
        cdb_set(2, 4'd6, 32'h666);
        step();
        cdb_off();
        step();
        check("t6_late_valid", bus.iss_valid, 1);
        check("t6_late_base", bus.iss_base, 32'h666);
        check("t6_late_dest", bus.iss_dest_tag, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
